// File: rtl/softmax_normalizer.sv
// ---------------------------------------------------------------------------
// softmax_normalizer
//   Final stage of the softmax datapath. Buffers the exponentials of one
//   vector while the reciprocal of their sum is computed upstream. Once the
//   reciprocal is valid, every buffered exponential is multiplied by it and
//   the clamped Q5.11 probabilities stream out one per cycle.
//
// Ports:
//   clk            clock, rising edge
//   arst           asynchronous active-high reset
//   i_clear        synchronous abort/restart (drops any sample in that cycle)
//   i_exp_valid    i_exp carries one exponential this cycle
//   i_exp          exponential, signed Q5.11
//   i_num          element count, sampled with the first accepted exponential
//   i_recip_valid  reciprocal valid (only the first valid cycle is used)
//   i_recip        reciprocal of the exponential sum, signed Q5.11
//   o_out          normalized probability, Q5.11, clamped to [0, 0x7FFF]
//   o_valid        o_out valid
//   o_last         final element of the vector
//   o_busy         vector in progress
//   o_err          sticky error (overflowed buffer or sample outside FILL)
//
// Optional feature:
//   SOFTMAX_NORM_ROUND_EN  round half up before the fractional shift;
//                          undefined gives plain truncation. Same latency.
// ---------------------------------------------------------------------------
module softmax_normalizer #(
  parameter int DWIDTH   = 16,
  parameter int FRAC_BIT = 11,
  parameter int CNT_BIT  = 16,
  parameter int DEPTH    = 64,
  parameter int ADDR_BIT = 6
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                i_clear,
  input  logic                i_exp_valid,
  input  logic [DWIDTH-1:0]   i_exp,
  input  logic [CNT_BIT-1:0]  i_num,
  input  logic                i_recip_valid,
  input  logic [DWIDTH-1:0]   i_recip,
  output logic [DWIDTH-1:0]   o_out,
  output logic                o_valid,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_err
);

  localparam int PW = 2 * DWIDTH;
  localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (DWIDTH - 1)) - 1);
  localparam logic [CNT_BIT-1:0]   DEPTH_C = CNT_BIT'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT_RECIP, S_DRAIN} state_t;

  state_t state, state_nxt;

  logic [CNT_BIT-1:0] num_q, wr_cnt, rd_ptr, drain_n;
  logic [DWIDTH-1:0]  recip_q, rd_data, sat_result;
  logic               rd_v, rd_last;
  logic [DWIDTH-1:0]  mem [DEPTH];

  logic                accept_first, fill_wr, overflow_wr, wr_en;
  logic                start_drain, rd_en, late_exp;
  logic [ADDR_BIT-1:0] wr_addr;
  logic signed [PW-1:0] prod, prod_adj, shifted;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept_first = (state == S_IDLE) && i_exp_valid && (i_num != '0);
    fill_wr      = (state == S_FILL) && i_exp_valid;
    overflow_wr  = fill_wr && (wr_cnt >= DEPTH_C);
    wr_en        = !i_clear && (accept_first || (fill_wr && !overflow_wr));
    wr_addr      = (state == S_IDLE) ? '0 : wr_cnt[ADDR_BIT-1:0];
    start_drain  = (state == S_WAIT_RECIP) && i_recip_valid;
    // Vectors longer than the buffer drain only what was stored.
    drain_n      = (num_q > DEPTH_C) ? DEPTH_C : num_q;
    // The first read is issued in the same cycle the reciprocal arrives so
    // the first product is ready two cycles later.
    rd_en        = (start_drain || (state == S_DRAIN)) && (rd_ptr < drain_n);
    late_exp     = i_exp_valid && ((state == S_WAIT_RECIP) || (state == S_DRAIN));
  end

  // Signed product, optional rounding, arithmetic shift, clamp to [0, MAX].
  always_comb begin
    prod = PW'($signed(rd_data)) * PW'($signed(recip_q));
`ifdef SOFTMAX_NORM_ROUND_EN
    prod_adj = prod + (PW'(1) <<< (FRAC_BIT - 1));
`else
    prod_adj = prod;
`endif
    shifted = prod_adj >>> FRAC_BIT;
    if (shifted < 0)            sat_result = '0;
    else if (shifted > SAT_MAX) sat_result = SAT_MAX[DWIDTH-1:0];
    else                        sat_result = shifted[DWIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:       if (accept_first)
                        state_nxt = (i_num == CNT_BIT'(1)) ? S_WAIT_RECIP : S_FILL;
        S_FILL:       if (i_exp_valid && (wr_cnt + CNT_BIT'(1) == num_q))
                        state_nxt = S_WAIT_RECIP;
        S_WAIT_RECIP: if (i_recip_valid) state_nxt = S_DRAIN;
        S_DRAIN:      if (o_valid && o_last) state_nxt = S_IDLE;
        default:      state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      num_q   <= '0;
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      recip_q <= '0;
      rd_v    <= 1'b0;
      rd_last <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_out   <= '0;
      o_err   <= 1'b0;
    end else if (i_clear) begin
      num_q   <= '0;
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      recip_q <= '0;
      rd_v    <= 1'b0;
      rd_last <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_out   <= '0;
      o_err   <= 1'b0;
    end else begin
      if (accept_first) begin
        num_q  <= i_num;
        wr_cnt <= CNT_BIT'(1);
      end else if (fill_wr) begin
        wr_cnt <= wr_cnt + CNT_BIT'(1);
      end
      if (accept_first)  rd_ptr <= '0;
      else if (rd_en)    rd_ptr <= rd_ptr + CNT_BIT'(1);
      if (start_drain)   recip_q <= i_recip;
      rd_v    <= rd_en;
      rd_last <= rd_en && (rd_ptr == drain_n - CNT_BIT'(1));
      o_valid <= rd_v;
      o_last  <= rd_v && rd_last;
      o_out   <= rd_v ? sat_result : '0;
      if (overflow_wr || late_exp) o_err <= 1'b1;
    end
  end

  // NOTE: the buffer and its read register carry no reset; their contents
  // are only consumed after being written, and omitting the reset lets the
  // array map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= i_exp;
    if (rd_en) rd_data <= mem[rd_ptr[ADDR_BIT-1:0]];
  end

  assign o_busy = (state != S_IDLE);

endmodule
